// File: rtl/rpu_layer_sched_pkg.sv
// Shared RPU definitions: default geometry of the layered decoder and the
// scheduler state encoding used by the row unit and its read scheduler.
package rpu_layer_sched_pkg;

  localparam int unsigned ADDRWIDTH_DEF = 5;
  localparam int unsigned ADDRDEPTH_DEF = 20;
  localparam int unsigned LAYERS_DEF    = 2;
  localparam int unsigned ITERBITS_DEF  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rpu_scoreboard.sv
// In-flight tracker: one bit per row address, set on read issue and cleared on
// write-back. Out-of-range addresses match no bit and are therefore ignored.
module rpu_scoreboard #(
  parameter int unsigned DEPTH     = 20,
  parameter int unsigned ADDRWIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set,
  input  logic [ADDRWIDTH-1:0] i_set_addr,
  input  logic                 i_clr,
  input  logic [ADDRWIDTH-1:0] i_clr_addr,
  input  logic [ADDRWIDTH-1:0] i_query_addr,
  output logic                 o_query_busy,
  output logic                 o_all_clear
);

  logic [DEPTH-1:0] r_sb;
  logic [DEPTH-1:0] w_set_mask;
  logic [DEPTH-1:0] w_clr_mask;

  always_comb begin
    w_set_mask   = '0;
    w_clr_mask   = '0;
    o_query_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_set && (i_set_addr == ADDRWIDTH'(i))) w_set_mask[i] = 1'b1;
      if (i_clr && (i_clr_addr == ADDRWIDTH'(i))) w_clr_mask[i] = 1'b1;
      if (i_query_addr == ADDRWIDTH'(i)) o_query_busy = r_sb[i];
    end
  end

  assign o_all_clear = (r_sb == '0);

  // A fresh issue wins over a write-back to the same address in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
    end
  end

endmodule

// File: rtl/rpu_layer_sched.sv
// Layered-decoder read scheduler: walks address/layer/iteration counters and
// issues row reads, stalling on rows whose previous write-back is outstanding.
module rpu_layer_sched
  import rpu_layer_sched_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int unsigned ADDRDEPTH = ADDRDEPTH_DEF,
  parameter int unsigned LAYERS    = LAYERS_DEF,
  parameter int unsigned ITERBITS  = ITERBITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 wren,
  input  logic                 wrlayer,
  input  logic [ADDRWIDTH-1:0] wraddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 busy,
  output logic                 done,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 stall
);

  localparam int unsigned LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [ADDRWIDTH-1:0] LastAddr  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [LW-1:0]        LastLayer = LW'(LAYERS - 1);

  sched_state_e         r_state;
  logic [ADDRWIDTH-1:0] r_addr;
  logic [LW-1:0]        r_layer;
  logic [ITERBITS-1:0]  r_iter;
  logic [ITERBITS-1:0]  r_last_iter;
  logic                 r_rden;
  logic                 r_rdlayer;
  logic [ADDRWIDTH-1:0] r_rdaddress;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_stall;

  logic w_hit;
  logic w_all_clear;
  logic w_issue;
  logic w_final;
  logic w_unused_wrlayer;

  // The write-back layer carries no scheduling information: rows are shared.
  assign w_unused_wrlayer = wrlayer;

  assign w_issue = (r_state == StRun) && !w_hit;
  assign w_final = (r_addr == LastAddr) && (r_layer == LastLayer) && (r_iter == r_last_iter);

  rpu_scoreboard #(
    .DEPTH     (ADDRDEPTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_scoreboard (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_set        (w_issue),
    .i_set_addr   (r_addr),
    .i_clr        (wren),
    .i_clr_addr   (wraddress),
    .i_query_addr (r_addr),
    .o_query_busy (w_hit),
    .o_all_clear  (w_all_clear)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_layer     <= '0;
      r_iter      <= '0;
      r_last_iter <= '0;
      r_rden      <= 1'b0;
      r_rdlayer   <= 1'b0;
      r_rdaddress <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_rden  <= 1'b0;
      r_stall <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StRun;
            r_busy      <= 1'b1;
            r_addr      <= '0;
            r_layer     <= '0;
            r_iter      <= '0;
            r_last_iter <= (max_iter == '0) ? '0 : max_iter - 1'b1;
          end
        end
        StRun: begin
          if (w_issue) begin
            r_rden      <= 1'b1;
            r_rdaddress <= r_addr;
            r_rdlayer   <= r_layer[0];
            // iter_count keeps the last iteration index after the final read.
            if (w_final) begin
              r_state <= StDrain;
              r_addr  <= '0;
              r_layer <= '0;
            end else if (r_addr == LastAddr) begin
              r_addr <= '0;
              if (r_layer == LastLayer) begin
                r_layer <= '0;
                r_iter  <= r_iter + 1'b1;
              end else begin
                r_layer <= r_layer + 1'b1;
              end
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end else begin
            r_stall <= 1'b1;
          end
        end
        StDrain: begin
          if (w_all_clear) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rden_LLR   = r_rden;
  assign rden_E     = r_rden;
  assign rdlayer    = r_rdlayer;
  assign rdaddress  = r_rdaddress;
  assign busy       = r_busy;
  assign done       = r_done;
  assign iter_count = r_iter;
  assign stall      = r_stall;

endmodule

// File: tb/tb_rpu_layer_sched.sv
// Bench for rpu_layer_sched: issue-index reference model compared every cycle,
// a write-back responder with configurable latency, and literal anchor checks.
module tb_rpu_layer_sched;

  localparam int AW  = 5;
  localparam int D   = 20;
  localparam int L   = 2;
  localparam int IB  = 4;
  localparam int NRD = D * L;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IB-1:0] max_iter = '0;
  logic          wren = 1'b0;
  logic          wrlayer = 1'b0;
  logic [AW-1:0] wraddress = '0;
  logic          rden_LLR, rden_E, rdlayer, busy, done, stall;
  logic [AW-1:0] rdaddress;
  logic [IB-1:0] iter_count;

  always #5 clk = ~clk;

  rpu_layer_sched #(
    .ADDRWIDTH (AW),
    .ADDRDEPTH (D),
    .LAYERS    (L),
    .ITERBITS  (IB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .max_iter   (max_iter),
    .wren       (wren),
    .wrlayer    (wrlayer),
    .wraddress  (wraddress),
    .rden_LLR   (rden_LLR),
    .rden_E     (rden_E),
    .rdlayer    (rdlayer),
    .rdaddress  (rdaddress),
    .busy       (busy),
    .done       (done),
    .iter_count (iter_count),
    .stall      (stall)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: reads are numbered k = 0,1,2...; address, layer and
  // iteration follow from k by division, and a row is blocked while in flight.
  int m_ph, m_k, m_mi, m_iss, m_a;
  bit m_sb [D];
  bit e_rden, e_stall, e_busy, e_done;
  int e_iter, e_layer, e_addr;

  function automatic bit model_all_clear();
    for (int i = 0; i < D; i++) if (m_sb[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_ph = 0; m_k = 0; m_mi = 1;
      for (int i = 0; i < D; i++) m_sb[i] = 1'b0;
      e_rden = 0; e_stall = 0; e_busy = 0; e_done = 0;
      e_iter = 0; e_layer = 0; e_addr = 0;
    end else begin
      m_iss = -1; e_rden = 0; e_stall = 0; e_done = 0;
      case (m_ph)
        0: if (start) begin
          m_mi = (max_iter == '0) ? 1 : int'(max_iter);
          m_k = 0; m_ph = 1; e_busy = 1; e_iter = 0;
        end
        1: begin
          m_a = m_k % D;
          if (m_sb[m_a]) e_stall = 1;
          else begin
            m_iss = m_a; e_rden = 1; e_addr = m_a; e_layer = (m_k / D) % L;
            m_k++;
            e_iter = (m_k / NRD < m_mi - 1) ? m_k / NRD : m_mi - 1;
            if (m_k == m_mi * NRD) m_ph = 2;
          end
        end
        2: if (model_all_clear()) begin m_ph = 3; e_done = 1; e_busy = 0; end
        default: m_ph = 0;
      endcase
      if (wren && int'(wraddress) < D) m_sb[int'(wraddress)] = 1'b0;
      if (m_iss >= 0) m_sb[m_iss] = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("ctrl", {rden_LLR, rden_E, stall, busy, done, iter_count},
            {e_rden, e_rden, e_stall, e_busy, e_done, IB'(e_iter)});
      if (e_rden) check("rd_addr", {rdlayer, rdaddress}, {e_layer[0], AW'(e_addr)});
    end
  end

  // Row-unit responder and per-run statistics.
  typedef struct { int addr; int layer; int due; } wb_t;
  wb_t q[$];
  int cyc = 0;
  int lat = 1;
  bit inj = 0;
  int st_reads, st_stalls, st_dones, last_wb_cyc, done_cyc;
  bit [15:0] st_iter_seen;
  int log_l [200];
  int log_a [200];

  task automatic step();
    wb_t w;
    int a;
    @(negedge clk);
    cyc++;
    if (rden_LLR) begin
      if (st_reads < 200) begin
        log_l[st_reads] = int'(rdlayer);
        log_a[st_reads] = int'(rdaddress);
      end
      st_reads++;
      st_iter_seen[iter_count] = 1'b1;
      w.addr = int'(rdaddress); w.layer = int'(rdlayer); w.due = cyc + lat;
      q.push_back(w);
    end
    if (stall) st_stalls++;
    if (done) begin st_dones++; done_cyc = cyc; end
    start = 1'b0; wren = 1'b0; wraddress = '0; wrlayer = 1'b0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      w = q.pop_front();
      wren = 1'b1; wraddress = AW'(w.addr); wrlayer = w.layer[0];
      last_wb_cyc = cyc;
    end else if (inj && $urandom_range(7) == 0) begin
      // Orphan write-back: out of range, or a row not currently in flight.
      a = int'($urandom_range(31));
      if (a < D && m_sb[a]) a = 25;
      wren = 1'b1; wraddress = AW'(a);
    end
    if (inj && busy && $urandom_range(15) == 0) begin
      start = 1'b1; max_iter = IB'($urandom);
    end
  endtask

  task automatic clear_stats();
    st_reads = 0; st_stalls = 0; st_dones = 0; st_iter_seen = '0;
    last_wb_cyc = 0; done_cyc = 0;
  endtask

  task automatic run_seq(input int mi, input int l, input bit inject);
    bit ok;
    int nexp;
    lat = l; inj = inject;
    clear_stats();
    step();
    start = 1'b1; max_iter = IB'(mi);
    for (int i = 0; i < 4000 && st_dones == 0; i++) step();
    for (int i = 0; i < 3; i++) step();
    nexp = ((mi == 0) ? 1 : mi) * NRD;
    check("read_count", st_reads, nexp);
    check("done_pulses", st_dones, 1);
    ok = 1'b1;
    for (int i = 0; i < st_reads && i < 200; i++)
      if (log_l[i] != (i / D) % L || log_a[i] != i % D) ok = 1'b0;
    check("issue_order", ok, 1'b1);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    @(negedge clk); @(negedge clk);
    check("reset_outputs", {rden_LLR, rden_E, rdlayer, rdaddress, busy, done, iter_count, stall}, '0);
    rst = 1'b1;

    // Immediate echo: 40 in-order reads, no stalls, done two cycles after last wren.
    run_seq(1, 1, 1'b0);
    check("echo_stalls", st_stalls, 0);
    check("echo_done_after_wb", done_cyc - last_wb_cyc, 2);

    // 11-cycle row unit: returns before the row is needed again.
    run_seq(1, 11, 1'b0);
    check("lat11_stalls", st_stalls, 0);

    // 25-cycle row unit: layer1 addr0 waits for its layer0 write-back.
    run_seq(1, 25, 1'b0);
    check("lat25_stalls", st_stalls, 7);

    run_seq(3, 1, 1'b0);
    check("iter_seen", st_iter_seen, 16'h0007);

    run_seq(0, 1, 1'b0);

    // Reset at read #17, then stray write-backs, then a clean run.
    lat = 3; inj = 1'b0;
    clear_stats();
    step();
    start = 1'b1; max_iter = IB'(1);
    for (int i = 0; i < 500 && st_reads < 17; i++) step();
    check("reached_read17", st_reads, 17);
    #2 rst = 1'b0;
    #1 check("reset_midrun_outputs",
             {rden_LLR, rden_E, rdlayer, rdaddress, busy, done, iter_count, stall}, '0);
    step(); step();
    rst = 1'b1;
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) begin wren = 1'b1; wraddress = AW'(7); end
    end
    check("post_reset_reads", st_reads, 0);
    check("post_reset_busy", busy, 1'b0);
    run_seq(1, 2, 1'b0);

    // Ignored starts and orphan write-backs.
    run_seq(1, 4, 1'b1);
    run_seq(2, 17, 1'b1);

    for (int r = 0; r < 8; r++)
      run_seq(int'($urandom_range(4)), int'($urandom_range(30, 1)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
